// File: rtl/psum_collector.sv
// Collects skewed per-lane partial sums into a per-lane accumulation buffer over
// several passes, then drains one entry index across all lanes per handshake.
module psum_collector #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned depth   = 16,
  parameter int unsigned vdly    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*psum_bw-1:0] in_psum,
  input  logic [col-1:0]         in_valid,
  input  logic                   start,
  input  logic [7:0]             num_tiles,
  input  logic                   relu_en,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [col*psum_bw-1:0] out_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned PtrW = $clog2(depth);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(depth - 1);
  localparam logic [psum_bw-1:0] SatMax = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] SatMin = {1'b1, {(psum_bw-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

  state_e state_q, state_d;
  logic [7:0]         ntl_q, ntl_d;
  logic               relu_q, relu_d;
  logic [PtrW-1:0]    rd_idx_q, rd_idx_d;
  logic               out_valid_q, out_valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [PtrW-1:0]    ptr_q [col];
  logic [PtrW-1:0]    ptr_d [col];
  logic [7:0]         tile_q [col];
  logic [7:0]         tile_d [col];
  logic [psum_bw-1:0] acc_q [col][depth];

  logic [col-1:0]     dv;
  logic [col*psum_bw-1:0] dp;
  logic [col-1:0]     lane_done;
  logic [col-1:0]     wr_en;
  logic               lane_err;
  logic [psum_bw-1:0] lane_in [col];
  logic [psum_bw-1:0] old_val [col];
  logic [psum_bw:0]   sum [col];
  logic [psum_bw-1:0] sat_val [col];
  logic [psum_bw-1:0] wr_data [col];
  logic [psum_bw-1:0] rd_val;

  // Valid/psum alignment pipeline; vdly=0 is a straight pass-through.
  if (vdly == 0) begin : g_nodly
    assign dv = in_valid;
    assign dp = in_psum;
  end else begin : g_dly
    logic [col-1:0]         dv_q [vdly];
    logic [col*psum_bw-1:0] dp_q [vdly];
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < int'(vdly); i++) begin
          dv_q[i] <= '0;
          dp_q[i] <= '0;
        end
      end else begin
        dv_q[0] <= in_valid;
        dp_q[0] <= in_psum;
        for (int i = 1; i < int'(vdly); i++) begin
          dv_q[i] <= dv_q[i-1];
          dp_q[i] <= dp_q[i-1];
        end
      end
    end
    assign dv = dv_q[vdly-1];
    assign dp = dp_q[vdly-1];
  end

  always_comb begin
    lane_err  = 1'b0;
    wr_en     = '0;
    lane_done = '0;
    for (int c = 0; c < int'(col); c++) begin
      ptr_d[c]     = ptr_q[c];
      tile_d[c]    = tile_q[c];
      lane_done[c] = (tile_q[c] == ntl_q);
      lane_in[c]   = dp[c*psum_bw +: psum_bw];
      old_val[c]   = acc_q[c][ptr_q[c]];
      sum[c]       = {lane_in[c][psum_bw-1], lane_in[c]} + {old_val[c][psum_bw-1], old_val[c]};
      // Overflow iff the extended sign disagrees with the result sign.
      if (sum[c][psum_bw] != sum[c][psum_bw-1]) begin
        sat_val[c] = sum[c][psum_bw] ? SatMin : SatMax;
      end else begin
        sat_val[c] = sum[c][psum_bw-1:0];
      end
      wr_data[c] = (tile_q[c] == 8'd0) ? lane_in[c] : sat_val[c];
      if (dv[c] && state_q != StIdle) begin
        if (state_q == StDrain || lane_done[c]) begin
          lane_err = 1'b1;
        end else begin
          wr_en[c] = 1'b1;
          ptr_d[c] = ptr_q[c] + PtrW'(1);
          if (ptr_q[c] == LastIdx) tile_d[c] = tile_q[c] + 8'd1;
        end
      end
      if (state_q == StIdle && start) begin
        ptr_d[c]  = '0;
        tile_d[c] = '0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ntl_d       = ntl_q;
    relu_d      = relu_q;
    rd_idx_d    = rd_idx_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q | lane_err;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StAccum;
          ntl_d    = (num_tiles == 8'd0) ? 8'd1 : num_tiles;
          relu_d   = relu_en;
          rd_idx_d = '0;
          err_d    = 1'b0;
        end
      end
      StAccum: begin
        if (start) err_d = 1'b1;
        if (&lane_done) state_d = StDrain;
      end
      StDrain: begin
        if (start) err_d = 1'b1;
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          rd_idx_d = rd_idx_q + PtrW'(1);
          if (rd_idx_q == LastIdx) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ntl_q       <= 8'd1;
      relu_q      <= 1'b0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int c = 0; c < int'(col); c++) begin
        ptr_q[c]  <= '0;
        tile_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ntl_q       <= ntl_d;
      relu_q      <= relu_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      for (int c = 0; c < int'(col); c++) begin
        ptr_q[c]  <= ptr_d[c];
        tile_q[c] <= tile_d[c];
      end
    end
  end

  // Buffer contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < int'(col); c++) begin
      if (wr_en[c]) acc_q[c][ptr_q[c]] <= wr_data[c];
    end
  end

  always_comb begin
    out_data = '0;
    rd_val   = '0;
    for (int c = 0; c < int'(col); c++) begin
      rd_val = acc_q[c][rd_idx_q];
      if (relu_q && rd_val[psum_bw-1]) rd_val = '0;
      if (out_valid_q) out_data[c*psum_bw +: psum_bw] = rd_val;
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_psum_collector.sv
// Randomized bench for psum_collector; expected drain data comes from a per-lane
// arithmetic model (entry = count mod depth, saturating sum, optional ReLU).
module tb_psum_collector;

  localparam int Col   = 8;
  localparam int Bw    = 16;
  localparam int Depth = 16;
  localparam int Vdly  = 1;
  localparam int W     = Col * Bw;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   in_psum;
  logic [Col-1:0] in_valid;
  logic           start;
  logic [7:0]     num_tiles;
  logic           relu_en;
  logic           out_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           busy;
  logic           done;
  logic           err;

  psum_collector #(
    .col    (Col),
    .psum_bw(Bw),
    .depth  (Depth),
    .vdly   (Vdly)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_psum  (in_psum),
    .in_valid (in_valid),
    .start    (start),
    .num_tiles(num_tiles),
    .relu_en  (relu_en),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int m [Col][Depth];
  int nin [Col];
  int ntl;
  bit relu;
  bit model_err;
  int vals [Col][64];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clamp(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic model_push(input int c, input int x);
    if (nin[c] < ntl * Depth) begin
      if (nin[c] < Depth) m[c][nin[c] % Depth] = x;
      else m[c][nin[c] % Depth] = clamp(m[c][nin[c] % Depth] + x);
      nin[c]++;
    end else begin
      model_err = 1'b1;
    end
  endtask

  function automatic logic [W-1:0] exp_entry(input int k);
    logic [W-1:0] e;
    int v;
    e = '0;
    for (int c = 0; c < Col; c++) begin
      v = m[c][k];
      if (relu && v < 0) v = 0;
      e[c*Bw +: Bw] = v[Bw-1:0];
    end
    return e;
  endfunction

  function automatic int gen(input int mode, input int k);
    case (mode)
      0:       return k + 1;
      1:       return 5;
      2:       return (k < Depth / 2) ? 30000 : -30000;
      default: return int'($urandom_range(0, 40000)) - 20000;
    endcase
  endfunction

  task automatic fill(input int mode, input int passes);
    for (int c = 0; c < Col; c++)
      for (int p = 0; p < passes; p++)
        for (int k = 0; k < Depth; k++) vals[c][p*Depth+k] = gen(mode, k);
  endtask

  task automatic start_job(input int num, input bit rel);
    num_tiles = 8'(num);
    relu_en   = rel;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    ntl       = (num == 0) ? 1 : num;
    relu      = rel;
    model_err = 1'b0;
    for (int c = 0; c < Col; c++) nin[c] = 0;
    check("busy_after_start", W'(busy), W'(1));
    check("err_after_start", W'(err), W'(0));
  endtask

  task automatic feed(input int passes, input int skew, input bit gaps, input bit extra0,
                      input bit mid_start);
    int pos [Col];
    int total;
    int t;
    int x;
    bit pending;
    bit extra_sent;
    total = passes * Depth;
    extra_sent = 1'b0;
    for (int c = 0; c < Col; c++) pos[c] = 0;
    t = 0;
    pending = 1'b1;
    while (pending && t < 3000) begin
      in_valid = '0;
      for (int c = 0; c < Col; c++) begin
        in_psum[c*Bw +: Bw] = Bw'($urandom);
        if (pos[c] < total && t >= c * skew && !(gaps && $urandom_range(0, 3) == 0)) begin
          x = vals[c][pos[c]];
          in_valid[c] = 1'b1;
          in_psum[c*Bw +: Bw] = x[Bw-1:0];
          model_push(c, x);
          pos[c]++;
        end
      end
      if (extra0 && !extra_sent && pos[0] == total && !in_valid[0]) begin
        x = 1234;
        in_valid[0] = 1'b1;
        in_psum[Bw-1:0] = x[Bw-1:0];
        model_push(0, x);
        extra_sent = 1'b1;
      end
      if (mid_start && t == 8) begin
        start     = 1'b1;
        num_tiles = 8'd7;
        model_err = 1'b1;
      end
      tick();
      start = 1'b0;
      t++;
      pending = 1'b0;
      for (int c = 0; c < Col; c++) if (pos[c] < total) pending = 1'b1;
    end
    in_valid = '0;
  endtask

  task automatic drain(input bit rnd, input int n_take);
    int idx;
    int cyc;
    bit rdy;
    bit v;
    logic [W-1:0] d;
    idx = 0;
    cyc = 0;
    while (idx < n_take && cyc < 400) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      v = out_valid;
      d = out_data;
      tick();
      cyc++;
      if (v && rdy) begin
        check($sformatf("drain_data[%0d]", idx), d, exp_entry(idx));
        idx++;
        check("done_flag", W'(done), W'(idx == Depth));
      end else if (v) begin
        check("stall_stable", out_data, d);
      end
    end
    out_ready = 1'b0;
    if (idx < n_take) check("drain_timeout", W'(idx), W'(n_take));
    if (n_take == Depth) begin
      check("err_flag", W'(err), W'(model_err));
      tick();
      check("done_drop", W'(done), W'(0));
      check("valid_drop", W'(out_valid), W'(0));
      check("idle_after_done", W'(busy), W'(0));
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_psum   = '0;
    in_valid  = '0;
    start     = 1'b0;
    num_tiles = 8'd0;
    relu_en   = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", W'(out_valid), W'(0));
    check("rst_data", out_data, '0);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_err", W'(err), W'(0));
    reset = 1'b0;
    tick();

    // Single pass, all lanes aligned, values 1..16.
    start_job(1, 1'b0);
    fill(0, 1);
    feed(1, 0, 1'b0, 1'b0, 1'b0);
    drain(1'b0, Depth);

    // Three passes of 5, lane c skewed by c cycles; check DRAIN entry latency.
    start_job(3, 1'b0);
    fill(1, 3);
    feed(3, 1, 1'b0, 1'b0, 1'b0);
    tick();
    check("drain_lat1", W'(out_valid), W'(0));
    tick();
    check("drain_lat2", W'(out_valid), W'(0));
    tick();
    check("drain_lat3", W'(out_valid), W'(1));
    drain(1'b0, Depth);

    // Saturation, without and with ReLU.
    start_job(2, 1'b0);
    fill(2, 2);
    feed(2, 0, 1'b0, 1'b0, 1'b0);
    drain(1'b0, Depth);
    start_job(2, 1'b1);
    fill(2, 2);
    feed(2, 0, 1'b0, 1'b0, 1'b0);
    drain(1'b0, Depth);

    // Random jobs with random gaps and random backpressure (num_tiles 0 acts as 1).
    for (int r = 0; r < 4; r++) begin
      start_job((r == 0) ? 0 : int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
      fill(3, ntl);
      feed(ntl, int'($urandom_range(0, 2)), 1'b1, 1'b0, 1'b0);
      drain(1'b1, Depth);
    end

    // Extra valid after lane 0 completes and a start during ACCUM.
    start_job(2, 1'b0);
    fill(3, 2);
    feed(2, 2, 1'b0, 1'b1, 1'b1);
    check("err_set", W'(err), W'(1));
    drain(1'b0, Depth);

    // Reset mid-DRAIN at entry 7, then a fresh job.
    start_job(1, 1'b0);
    fill(3, 1);
    feed(1, 0, 1'b1, 1'b0, 1'b0);
    drain(1'b0, 7);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", W'(out_valid), W'(0));
    check("mid_rst_data", out_data, '0);
    check("mid_rst_busy", W'(busy), W'(0));
    check("mid_rst_done", W'(done), W'(0));
    tick();
    check("mid_rst_nodone", W'(done), W'(0));
    reset = 1'b0;
    tick();
    check("post_rst_done", W'(done), W'(0));
    start_job(2, 1'b1);
    fill(3, 2);
    feed(2, 1, 1'b1, 1'b0, 1'b0);
    drain(1'b1, Depth);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
